// File: rtl/ika2151_pkg.sv
// Shared constants for the IKA2151 timer control block: register map, control-register
// bit positions and CSM state encoding.
package ika2151_pkg;

    localparam logic [7:0] AddrClkA1 = 8'h10;
    localparam logic [7:0] AddrClkA2 = 8'h11;
    localparam logic [7:0] AddrClkB  = 8'h12;
    localparam logic [7:0] AddrCtrl  = 8'h14;

    localparam int unsigned BitRunA   = 0;
    localparam int unsigned BitRunB   = 1;
    localparam int unsigned BitIrqEnA = 2;
    localparam int unsigned BitIrqEnB = 3;
    localparam int unsigned BitFrstA  = 4;
    localparam int unsigned BitFrstB  = 5;
    localparam int unsigned BitCsm    = 7;

    localparam logic [1:0] CsmIdle  = 2'b00;
    localparam logic [1:0] CsmWait  = 2'b01;
    localparam logic [1:0] CsmKeyon = 2'b10;

endpackage

// File: rtl/ika2151_timerctrl_csm.sv
// CSM (composite sine mode) key-on sequencer: a timer A overflow arms it, the next frame
// boundary starts a key-on pulse lasting CSM_CYCLES enabled cycles.
module ika2151_timerctrl_csm
    import ika2151_pkg::*;
#(
    parameter int unsigned CSM_CYCLES = 32
) (
    input  logic i_EMUCLK,
    input  logic i_MRST,
    input  logic i_phi1_NCEN_n,
    input  logic i_CYCLE_31,
    input  logic i_CSM,
    input  logic i_TIMERA_OVFL,
    output logic o_CSM_KEYON
);

    localparam logic [5:0] LastCnt = 6'(CSM_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CsmIdle: begin
                if (i_TIMERA_OVFL && i_CSM) state_d = CsmWait;
            end
            CsmWait: begin
                if (!i_CSM) begin
                    state_d = CsmIdle;
                end else if (i_CYCLE_31) begin
                    state_d = CsmKeyon;
                    cnt_d   = '0;
                end
            end
            CsmKeyon: begin
                // Runs to completion regardless of CSM or further overflows.
                if (cnt_q == LastCnt) begin
                    state_d = CsmIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = CsmIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_phi1_NCEN_n) begin
            if (i_MRST) begin
                state_q <= CsmIdle;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    assign o_CSM_KEYON = (state_q == CsmKeyon);

endmodule

// File: rtl/ika2151_timerctrl.sv
// IKA2151 timer control registers, flag-reset requests and IRQ output.
// CSM key-on support is built only when IKA2151_TIMERCTRL_CSM_EN is defined.
module ika2151_timerctrl
    import ika2151_pkg::*;
#(
    parameter int unsigned CSM_CYCLES = 32
) (
    input  logic       i_EMUCLK,
    input  logic       i_MRST,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_CYCLE_31,
    input  logic       i_WR,
    input  logic [7:0] i_ADDR,
    input  logic [7:0] i_DATA,
    input  logic       i_TIMERA_FLAG,
    input  logic       i_TIMERB_FLAG,
    input  logic       i_TIMERA_OVFL,
    output logic [7:0] o_CLKA1,
    output logic [1:0] o_CLKA2,
    output logic [7:0] o_CLKB,
    output logic       o_TIMERA_RUN,
    output logic       o_TIMERB_RUN,
    output logic       o_TIMERA_IRQ_EN,
    output logic       o_TIMERB_IRQ_EN,
    output logic       o_TIMERA_FRST,
    output logic       o_TIMERB_FRST,
    output logic       o_IRQ_n,
    output logic       o_CSM_KEYON
);

    logic [7:0] clka1_q, clka1_d;
    logic [1:0] clka2_q, clka2_d;
    logic [7:0] clkb_q, clkb_d;
    logic       run_a_q, run_a_d, run_b_q, run_b_d;
    logic       irqen_a_q, irqen_a_d, irqen_b_q, irqen_b_d;
    logic       frst_a_q, frst_a_d, frst_b_q, frst_b_d;
    logic       irq_n_q, irq_n_d;
    logic       csm_q, csm_d;

    always_comb begin
        clka1_d   = clka1_q;
        clka2_d   = clka2_q;
        clkb_d    = clkb_q;
        run_a_d   = run_a_q;
        run_b_d   = run_b_q;
        irqen_a_d = irqen_a_q;
        irqen_b_d = irqen_b_q;
        csm_d     = csm_q;
        // Pending flag resets retire at the frame boundary; a new request overrides below.
        frst_a_d  = frst_a_q & ~i_CYCLE_31;
        frst_b_d  = frst_b_q & ~i_CYCLE_31;
        irq_n_d   = ~(i_TIMERA_FLAG | i_TIMERB_FLAG);
        if (i_WR) begin
            case (i_ADDR)
                AddrClkA1: clka1_d = i_DATA;
                AddrClkA2: clka2_d = i_DATA[1:0];
                AddrClkB:  clkb_d  = i_DATA;
                AddrCtrl: begin
                    run_a_d   = i_DATA[BitRunA];
                    run_b_d   = i_DATA[BitRunB];
                    irqen_a_d = i_DATA[BitIrqEnA];
                    irqen_b_d = i_DATA[BitIrqEnB];
                    if (i_DATA[BitFrstA]) frst_a_d = 1'b1;
                    if (i_DATA[BitFrstB]) frst_b_d = 1'b1;
`ifdef IKA2151_TIMERCTRL_CSM_EN
                    csm_d = i_DATA[BitCsm];
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_phi1_NCEN_n) begin
            if (i_MRST) begin
                clka1_q   <= '0;
                clka2_q   <= '0;
                clkb_q    <= '0;
                run_a_q   <= 1'b0;
                run_b_q   <= 1'b0;
                irqen_a_q <= 1'b0;
                irqen_b_q <= 1'b0;
                frst_a_q  <= 1'b0;
                frst_b_q  <= 1'b0;
                irq_n_q   <= 1'b1;
                csm_q     <= 1'b0;
            end else begin
                clka1_q   <= clka1_d;
                clka2_q   <= clka2_d;
                clkb_q    <= clkb_d;
                run_a_q   <= run_a_d;
                run_b_q   <= run_b_d;
                irqen_a_q <= irqen_a_d;
                irqen_b_q <= irqen_b_d;
                frst_a_q  <= frst_a_d;
                frst_b_q  <= frst_b_d;
                irq_n_q   <= irq_n_d;
                csm_q     <= csm_d;
            end
        end
    end

    assign o_CLKA1         = clka1_q;
    assign o_CLKA2         = clka2_q;
    assign o_CLKB          = clkb_q;
    assign o_TIMERA_RUN    = run_a_q;
    assign o_TIMERB_RUN    = run_b_q;
    assign o_TIMERA_IRQ_EN = irqen_a_q;
    assign o_TIMERB_IRQ_EN = irqen_b_q;
    assign o_TIMERA_FRST   = frst_a_q;
    assign o_TIMERB_FRST   = frst_b_q;
    assign o_IRQ_n         = irq_n_q;

`ifdef IKA2151_TIMERCTRL_CSM_EN
    ika2151_timerctrl_csm #(
        .CSM_CYCLES(CSM_CYCLES)
    ) u_csm (
        .i_EMUCLK     (i_EMUCLK),
        .i_MRST       (i_MRST),
        .i_phi1_NCEN_n(i_phi1_NCEN_n),
        .i_CYCLE_31   (i_CYCLE_31),
        .i_CSM        (csm_q),
        .i_TIMERA_OVFL(i_TIMERA_OVFL),
        .o_CSM_KEYON  (o_CSM_KEYON)
    );
`else
    // csm_q is held at zero by its next-state default; the overflow input goes nowhere.
    logic unused_csm;
    assign unused_csm  = ^{i_TIMERA_OVFL, csm_q, CSM_CYCLES};
    assign o_CSM_KEYON = 1'b0;
`endif

endmodule

// File: tb/tb_ika2151_timerctrl.sv
// Self-checking bench for ika2151_timerctrl: register vector table plus frame-timed
// sequences for flag reset, CSM key-on and reset abort.
module tb_ika2151_timerctrl;

`ifdef IKA2151_TIMERCTRL_CSM_EN
    localparam bit CsmEn = 1'b1;
`else
    localparam bit CsmEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       mrst = 1'b0, ncen = 1'b0, cyc31 = 1'b0, wr = 1'b0;
    logic [7:0] addr = '0, data = '0;
    logic       fa = 1'b0, fb = 1'b0, ovfl = 1'b0;
    logic [7:0] clka1, clkb;
    logic [1:0] clka2;
    logic       run_a, run_b, irqen_a, irqen_b, frst_a, frst_b, irq_n, keyon;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ika2151_timerctrl dut (
        .i_EMUCLK       (clk),
        .i_MRST         (mrst),
        .i_phi1_NCEN_n  (ncen),
        .i_CYCLE_31     (cyc31),
        .i_WR           (wr),
        .i_ADDR         (addr),
        .i_DATA         (data),
        .i_TIMERA_FLAG  (fa),
        .i_TIMERB_FLAG  (fb),
        .i_TIMERA_OVFL  (ovfl),
        .o_CLKA1        (clka1),
        .o_CLKA2        (clka2),
        .o_CLKB         (clkb),
        .o_TIMERA_RUN   (run_a),
        .o_TIMERB_RUN   (run_b),
        .o_TIMERA_IRQ_EN(irqen_a),
        .o_TIMERB_IRQ_EN(irqen_b),
        .o_TIMERA_FRST  (frst_a),
        .o_TIMERB_FRST  (frst_b),
        .o_IRQ_n        (irq_n),
        .o_CSM_KEYON    (keyon)
    );

    typedef struct {
        logic       mrst;
        logic       ncen;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic       fa;
        logic       fb;
        logic [7:0] e_clka1;
        logic [1:0] e_clka2;
        logic [7:0] e_clkb;
        logic [3:0] e_ctrl;   // {run_a, run_b, irqen_a, irqen_b}
        logic       e_irq_n;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [25:0] outs();
        return {clka1, clka2, clkb, run_a, run_b, irqen_a, irqen_b, frst_a, frst_b, irq_n, keyon};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        mrst = 1'b0; ncen = 1'b0; wr = 1'b0; addr = '0; data = '0;
        fa = 1'b0; fb = 1'b0; ovfl = 1'b0; cyc31 = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        mrst = 1'b1;
        step();
        mrst = 1'b0;
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; data = d;
    endtask

    initial begin
        //            mrst ncen wr  addr   data   fa fb  clka1  a2    clkb   ctrl     irq_n
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 4'b0000, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'hA5, 2'd0, 8'h00, 4'b0000, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h11, 8'h03, 1'b0, 1'b0, 8'hA5, 2'd3, 8'h00, 4'b0000, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h12, 8'h7E, 1'b0, 1'b0, 8'hA5, 2'd3, 8'h7E, 4'b0000, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h13, 8'hFF, 1'b0, 1'b0, 8'hA5, 2'd3, 8'h7E, 4'b0000, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h14, 8'h0F, 1'b0, 1'b0, 8'hA5, 2'd3, 8'h7E, 4'b1111, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5, 2'd3, 8'h7E, 4'b1111, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA5, 2'd3, 8'h7E, 4'b1111, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hA5, 2'd3, 8'h7E, 4'b1111, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 1'b1, 1'b0, 8'hA5, 2'd3, 8'h7E, 4'b1111, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'hA5, 2'd3, 8'h7E, 4'b1111, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h14, 8'h05, 1'b0, 1'b0, 8'hA5, 2'd3, 8'h7E, 4'b1010, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h11, 8'hFE, 1'b0, 1'b0, 8'hA5, 2'd2, 8'h7E, 4'b1010, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h15, 8'hFF, 1'b0, 1'b0, 8'hA5, 2'd2, 8'h7E, 4'b1010, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h10, 8'hFF, 1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 4'b0000, 1'b1};

        quiet();
        for (int i = 0; i < 15; i++) begin
            mrst = vecs[i].mrst; ncen = vecs[i].ncen; wr = vecs[i].wr;
            addr = vecs[i].addr; data = vecs[i].data; fa = vecs[i].fa; fb = vecs[i].fb;
            step();
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({vecs[i].e_clka1, vecs[i].e_clka2, vecs[i].e_clkb, vecs[i].e_ctrl,
                       2'b00, vecs[i].e_irq_n, 1'b0}));
        end

        // Flag reset: requested at cycle 5, re-requested at 20, untouched by 0x0F at 12.
        do_reset();
        for (int c = 0; c < 46; c++) begin
            quiet();
            cyc31 = (c % 32 == 31);
            if (c == 5 || c == 20) set_wr(8'h14, 8'h30);
            if (c == 12) set_wr(8'h14, 8'h0F);
            step();
            check($sformatf("frst_c%0d", c), 32'({frst_a, frst_b}),
                  (c >= 5 && c <= 30) ? 32'h3 : 32'h0);
        end

        // CSM armed, overflow at 10, ignored overflow at 40 during key-on.
        do_reset();
        for (int c = 0; c < 71; c++) begin
            quiet();
            cyc31 = (c % 32 == 31);
            if (c == 0) set_wr(8'h14, 8'h80);
            if (c == 10 || c == 40) ovfl = 1'b1;
            step();
            check($sformatf("keyon_c%0d", c), 32'(keyon),
                  32'(CsmEn && c >= 31 && c <= 62));
        end

        // CSM cleared while waiting for the frame boundary: no key-on.
        do_reset();
        for (int c = 0; c < 71; c++) begin
            quiet();
            cyc31 = (c % 32 == 31);
            if (c == 0) set_wr(8'h14, 8'h80);
            if (c == 5) ovfl = 1'b1;
            if (c == 10) set_wr(8'h14, 8'h00);
            step();
            check($sformatf("csmclr_c%0d", c), 32'(keyon), 32'h0);
        end

        // Reset in the middle of key-on aborts everything, write during reset ignored.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            quiet();
            cyc31 = (c % 32 == 31);
            if (c == 0) set_wr(8'h14, 8'h8F);
            if (c == 1) set_wr(8'h10, 8'h55);
            if (c == 3) ovfl = 1'b1;
            step();
        end
        check("pre_reset", 32'(outs()),
              32'({8'h55, 2'b00, 8'h00, 4'hF, 2'b00, 1'b1, CsmEn}));
        quiet();
        mrst = 1'b1;
        set_wr(8'h10, 8'hFF);
        step();
        check("mid_keyon_reset", 32'(outs()), 32'h2);
        for (int c = 41; c < 81; c++) begin
            quiet();
            cyc31 = (c % 32 == 31);
            step();
            check($sformatf("post_reset_c%0d", c), 32'(keyon), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ika2151_timerctrl.md
IKA2151_TIMERCTRL -- requirements
Module: ika2151_timerctrl

Interface
REQ-001 SHALL have parameter CSM_CYCLES, default 32: length of the CSM key-on pulse in enabled phi1 cycles (one 32-slot frame).
REQ-002 SHALL have port i_EMUCLK, input, 1 bit: emulator master clock, the only clock.
REQ-003 SHALL have port i_MRST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_phi1_NCEN_n, input, 1 bit: active-low clock enable; all state updates occur on i_EMUCLK rising edges where it is 0 ("enabled edge").
REQ-005 SHALL have port i_CYCLE_31, input, 1 bit: frame boundary timing strobe.
REQ-006 SHALL have ports i_WR (input, 1 bit, write strobe), i_ADDR (input, 8 bits, register address) and i_DATA (input, 8 bits, write data).
REQ-007 SHALL have ports i_TIMERA_FLAG, i_TIMERB_FLAG and i_TIMERA_OVFL, inputs, 1 bit each, driven from the timer block.
REQ-008 SHALL have ports o_CLKA1 (output, 8 bits), o_CLKA2 (output, 2 bits) and o_CLKB (output, 8 bits): timer reload values.
REQ-009 SHALL have ports o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN and o_TIMERB_IRQ_EN, outputs, 1 bit each.
REQ-010 SHALL have ports o_TIMERA_FRST and o_TIMERB_FRST, outputs, 1 bit each: flag-reset requests to the timer.
REQ-011 SHALL have ports o_IRQ_n (output, 1 bit, active-low interrupt) and o_CSM_KEYON (output, 1 bit, all-channel key-on request).

Function
REQ-012 SHALL decode a write on each enabled edge with i_WR=1; addresses other than 0x10, 0x11, 0x12 and 0x14 SHALL be ignored.
REQ-013 SHALL handle each register write as follows: 0x10 loads o_CLKA1 from i_DATA; 0x11 loads o_CLKA2 from i_DATA[1:0]; 0x12 loads o_CLKB from i_DATA.
REQ-014 SHALL, on a write to 0x14, load CSM from bit7, o_TIMERB_IRQ_EN from bit3, o_TIMERA_IRQ_EN from bit2, o_TIMERB_RUN from bit1 and o_TIMERA_RUN from bit0.
REQ-015 SHALL make register outputs visible one enabled edge after the write is sampled.
REQ-016 SHALL, on a write to 0x14 with bit4 (A) or bit5 (B) set, assert the corresponding FRST output from the next enabled edge until the first enabled edge where i_CYCLE_31=1 has been sampled, then deassert it.
REQ-017 SHALL treat a further FRST write while the request is pending as extending that same request; no second pulse is generated.
REQ-018 SHALL treat a 0x14 write with bit4=0 and bit5=0 as leaving pending FRST requests untouched.
REQ-019 SHALL register o_IRQ_n as ~(i_TIMERA_FLAG | i_TIMERB_FLAG), with 1 enabled-cycle latency.
REQ-020 SHALL implement the CSM FSM states IDLE, WAIT and KEYON.
REQ-021 SHALL transition IDLE->WAIT on i_TIMERA_OVFL=1 with CSM=1.
REQ-022 SHALL transition WAIT->KEYON on an enabled edge with i_CYCLE_31=1.
REQ-023 SHALL transition KEYON->IDLE after CSM_CYCLES enabled edges, using a counter 6 bits wide that wraps to 0.
REQ-024 SHALL drive o_CSM_KEYON to 1 only in KEYON.
REQ-025 SHALL ignore i_TIMERA_OVFL while in WAIT or KEYON.
REQ-026 SHALL return the FSM from WAIT to IDLE when CSM is cleared while in WAIT; a KEYON that has already started SHALL complete.
REQ-027 SHALL process a write setting CSM and an overflow on the same edge using the old CSM value.

Reset
REQ-028 SHALL, on an enabled edge with i_MRST=1, clear all registers and outputs to 0 (o_IRQ_n=1, FSM=IDLE, counter=0, FRST requests cleared) and ignore i_WR.
REQ-029 SHALL abort any in-progress operation immediately on reset, with no residual pulse.

Configuration
REQ-030 SHALL include the CSM register bit, the FSM and o_CSM_KEYON functionality when macro IKA2151_TIMERCTRL_CSM_EN is defined.
REQ-031 SHALL, when IKA2151_TIMERCTRL_CSM_EN is undefined, tie o_CSM_KEYON to 0, ignore bit7 of register 0x14 and synthesize no FSM logic; all other behaviour is unchanged.

Structure
REQ-032 SHALL take the register address constants (0x10/0x11/0x12/0x14), the 0x14 bit positions and the CSM state encoding from shared package ika2151_pkg.
REQ-033 SHALL place the CSM FSM and its counter in sub-module ika2151_timerctrl_csm, instantiated only under IKA2151_TIMERCTRL_CSM_EN.

Verification
REQ-034 SHALL cover: write 0x10=0xA5, 0x11=0x03, 0x12=0x7E -> o_CLKA1=0xA5, o_CLKA2=3, o_CLKB=0x7E one enabled edge later; write 0x13=0xFF -> no output changes.
REQ-035 SHALL cover: write 0x14=0x0F -> both RUN=1 and both IRQ_EN=1; then i_TIMERA_FLAG=1 -> o_IRQ_n=0 after 1 cycle.
REQ-036 SHALL cover: write 0x14=0x30 at cycle 5 -> both FRST held high until the cycle-31 edge, low afterwards; second 0x30 write at cycle 20 -> still a single pulse.
REQ-037 SHALL cover: CSM=1, OVFL pulse at cycle 10 -> o_CSM_KEYON rises after the cycle-31 edge and stays high exactly 32 enabled cycles; a second OVFL during KEYON has no effect.
REQ-038 SHALL cover: CSM cleared during WAIT -> no key-on occurs; i_MRST asserted mid-KEYON -> o_CSM_KEYON=0 and all outputs at reset values next edge.
REQ-039 SHALL cover: with IKA2151_TIMERCTRL_CSM_EN undefined, rerun the CSM scenario -> o_CSM_KEYON stays 0.
